// File: rtl/vga_fb_reader.sv
// Read DMA: streams one 256x256 half of the 512-wide frame buffer through a 4-entry show-ahead FIFO.
// Define VGA_FB_RD_VFLIP_EN to read rows bottom-to-top (row 255 first).
module vga_fb_reader #(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             img_idx,
    output logic [16:0]      raddr,
    output logic             re,
    input  logic [PIX_W-1:0] rdata,
    output logic [PIX_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

`ifdef VGA_FB_RD_VFLIP_EN
    localparam logic [7:0] ROW_FIRST = 8'hFF;
    localparam logic [7:0] ROW_STEP  = 8'hFF;  // two's-complement -1
`else
    localparam logic [7:0] ROW_FIRST = 8'h00;
    localparam logic [7:0] ROW_STEP  = 8'h01;
`endif
    localparam logic [16:0] LAST_ISSUE = 17'd65535;

    state_e           state_q, state_d;
    logic [7:0]       row_q, row_d;
    logic [7:0]       col_q, col_d;
    logic             img_q, img_d;
    logic [16:0]      issued_q, issued_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;
    logic [2:0]       count_upd;
    logic             done_q, done_d;
    logic [PIX_W-1:0] fifo_q [4];
    logic             push;
    logic             pop;
    logic             push_en;

    // Credit covers both FIFO occupancy and the read still in the memory pipeline,
    // so every returned word has a guaranteed slot.
    assign re        = (state_q == S_RUN) && (({1'b0, count_q} + {3'b000, inflight_q}) < 4'd4);
    assign raddr     = {row_q, img_q, col_q};
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign out_valid = (count_q != 3'd0);
    assign out_data  = fifo_q[rd_ptr_q];

    assign push      = inflight_q;
    assign pop       = out_valid & out_ready;
    assign push_en   = push & ~start;
    assign count_upd = count_q + {2'b00, push} - {2'b00, pop};

    // NOTE: every next-state value gets a default before any branch, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        img_d      = img_q;
        issued_d   = issued_q;
        inflight_d = re;
        wr_ptr_d   = wr_ptr_q + {1'b0, push};
        rd_ptr_d   = rd_ptr_q + {1'b0, pop};
        count_d    = count_upd;
        done_d     = 1'b0;

        if (state_q == S_DRAIN && count_upd == 3'd0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
        end

        if (re) begin
            col_d    = col_q + 8'd1;
            issued_d = issued_q + 17'd1;
            if (col_q == 8'hFF) begin
                row_d = row_q + ROW_STEP;
            end
            if (issued_q == LAST_ISSUE) begin
                state_d = S_DRAIN;
            end
        end

        // Start (or restart) wins over everything except the done pulse of a frame
        // that finishes on this same edge.
        if (start) begin
            state_d    = S_RUN;
            row_d      = ROW_FIRST;
            col_d      = 8'd0;
            img_d      = img_idx;
            issued_d   = 17'd0;
            inflight_d = 1'b0;
            wr_ptr_d   = 2'd0;
            rd_ptr_d   = 2'd0;
            count_d    = 3'd0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together
    // and the order of always_ff blocks cannot change the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            row_q      <= 8'd0;
            col_q      <= 8'd0;
            img_q      <= 1'b0;
            issued_q   <= 17'd0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            img_q      <= img_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            done_q     <= done_d;
        end
    end

    // NOTE: the FIFO storage is reset because out_data is read straight from it and
    // must show 0 after reset; at four entries this costs little.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push_en) begin
            fifo_q[wr_ptr_q] <= rdata;
        end
    end

endmodule
